layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
// - Parametrised successor to the fixed six-state layer control FSM. Sequences NUM_STAGES accelerator
//   stages (conv/pool/FC/result) in index order under one start command.
// - Adds per-stage skip mask, stage-entry start pulses, per-stage watchdog timeout with error capture,
//   abort, and re-run from DONE.
// - Sits at top level between the host start/finish interface and the per-layer engines' en/done pairs.
// PARAMETERS
// - NUM_STAGES      6          number of sequenced stages (>=2)
// - IDX_W           $clog2(NUM_STAGES)   width of stage index outputs
// - TIMEOUT_CYCLES  1000000    max cycles a stage may stay enabled; 0 disables watchdog
// - TIMEOUT_W       20         watchdog counter width; must hold TIMEOUT_CYCLES-1
// PORTS
// - clk          in   1           clock, all logic on posedge
// - rst_n        in   1           asynchronous reset, active-low
// - start        in   1           begin a run (sampled in IDLE and DONE only)
// - abort        in   1           return to IDLE from any state; highest priority
// - stage_skip   in   NUM_STAGES  1 = bypass stage i; latched when start is accepted
// - stage_done   in   NUM_STAGES  stage i complete; only bit of the current stage is observed
// - stage_en     out  NUM_STAGES  one-hot level enable of the current stage (all 0 outside RUN)
// - stage_start  out  NUM_STAGES  one-cycle pulse on the first cycle of stage_en[i]
// - cur_stage    out  IDX_W       index of the active stage (0 outside RUN)
// - busy         out  1           1 in RUN
// - finish       out  1           level, 1 in DONE
// - timeout_err  out  1           level, 1 in ERROR
// - err_stage    out  IDX_W       index of the stage that timed out; valid while timeout_err
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; every output 0; skip latch, index and watchdog cleared.
// - States: IDLE, RUN, DONE, ERROR. All outputs registered; no combinational input->output path.
// - IDLE: start=1 -> latch stage_skip; idx = lowest non-skipped stage -> RUN. All stages skipped -> DONE.
//   stage_en/stage_start of the first stage rise the cycle after start is sampled.
// - RUN: stage_en = 1<<idx. stage_start[idx] = 1 on the entry cycle only. Watchdog cleared on entry.
//   stage_done[idx]=1 (also on the entry cycle) -> idx = next higher non-skipped stage, with a fresh
//   entry pulse next cycle; no such stage -> DONE. Min one cycle per stage. Done bits of other stages,
//   and done held high across a transition, are ignored except by the newly entered stage as stated.
// - Watchdog: counts cycles in the current stage; reaching TIMEOUT_CYCLES-1 with no done -> ERROR,
//   err_stage=idx. Done and timeout in the same cycle: done wins.
// - DONE: finish=1. start=1 -> relatch skip, begin new run (finish drops the same edge). Unlike the old
//   FSM, DONE is not terminal.
// - ERROR: timeout_err=1, err_stage held, start ignored; only abort or reset leaves.
// - abort=1 in any state -> IDLE next cycle, all outputs 0; overrides start, done and timeout.
//   Stages must treat stage_en fall as cancel.
// - Index never wraps; skip changes after start have no effect until the next start.
// STRUCTURE
// - Shared package/include seq_pkg: state encodings (one-hot, 4 bits), IDX_W helper function,
//   default TIMEOUT_CYCLES.
// - One sub-module: seq_watchdog (clear, enable, TIMEOUT_W counter, expire flag at TIMEOUT_CYCLES-1;
//   tied off when TIMEOUT_CYCLES=0).
// - Next-stage search: priority encoder over ~skip_q masked above idx, inline function.
// TESTING
// - Reset mid-RUN at stage 3: deassert rst_n asynchronously -> all outputs 0 without clk edge; IDLE after release.
// - NUM_STAGES=6, skip=0, each done 4 cycles after stage_start -> en walks 0..5, six stage_start pulses,
//   finish rises one cycle after done[5]; cur_stage tracks 0..5.
// - skip=6'b010110 -> only stages 0,3,5 enabled in order; skip=6'b111111 -> DONE one cycle after start, no en.
// - stage_done held at 6'b111111 continuously -> each stage enabled exactly one cycle; finish 7 cycles after start.
// - TIMEOUT_CYCLES=16, stage 2 never done -> ERROR 16 cycles after stage_start[2], err_stage=2;
//   start ignored; abort -> IDLE.
// - abort and done[idx] in same cycle -> IDLE; start in DONE -> new run, finish cleared.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the layer sequencer: state encodings, index-width helper
// and default watchdog sizing.
package seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DONE  = 4'b0100,
        S_ERROR = 4'b1000
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;
    localparam int unsigned DEFAULT_TIMEOUT_W      = 20;

    // Index width for n stages, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TIMEOUT_CYCLES-1. Tied off when TIMEOUT_CYCLES=0.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

            logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
            logic                 expire_q, expire_d;

            // Clear wins over count; flag is registered from the next count value.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
                expire_d = (cnt_d == LIMIT);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    expire_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    expire_q <= expire_d;
                end
            end

            assign expire_o = expire_q;
        end
    endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Sequences NUM_STAGES accelerator stages in index order with skip mask, entry pulses,
// per-stage watchdog, abort and re-run from DONE. All outputs are registered.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 6,
    parameter int unsigned IDX_W          = idx_width(NUM_STAGES),
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_W      = DEFAULT_TIMEOUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_skip,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [IDX_W-1:0]      cur_stage,
    output logic                  busy,
    output logic                  finish,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      err_stage
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] skip_q, skip_d;
    logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
    logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;
    logic                  terr_q, terr_d;
    logic [IDX_W-1:0]      err_stage_q, err_stage_d;

    logic                  wd_clear, wd_en, wd_expire;
    logic [IDX_W:0]        first_c, next_c;

    // Lowest available stage at or above lo; MSB of the result is the found flag.
    function automatic logic [IDX_W:0] find_stage(input logic [NUM_STAGES-1:0] avail,
                                                  input int unsigned           lo);
        logic [IDX_W:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (avail[i] && (i >= lo) && !r[IDX_W]) begin
                r = {1'b1, IDX_W'(i)};
            end
        end
        return r;
    endfunction

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (wd_clear),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        skip_d        = skip_q;
        err_stage_d   = '0;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;
        stage_en_d    = '0;
        stage_start_d = '0;
        busy_d        = 1'b0;
        finish_d      = 1'b0;
        terr_d        = 1'b0;
        first_c       = find_stage(~stage_skip, 32'd0);
        next_c        = find_stage(~skip_q, 32'(idx_q) + 32'd1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    skip_d = stage_skip;
                    if (first_c[IDX_W]) begin
                        state_d  = S_RUN;
                        idx_d    = first_c[IDX_W-1:0];
                        wd_clear = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end
                end
            end
            S_RUN: begin
                wd_en = 1'b1;
                if (stage_done[idx_q]) begin
                    if (next_c[IDX_W]) begin
                        idx_d    = next_c[IDX_W-1:0];
                        wd_clear = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end
                end else if (wd_expire) begin
                    state_d     = S_ERROR;
                    idx_d       = '0;
                    err_stage_d = idx_q;
                end
            end
            S_ERROR: begin
                err_stage_d = err_stage_q;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            err_stage_d = '0;
            wd_clear    = 1'b0;
        end

        case (state_d)
            S_RUN: begin
                stage_en_d    = NUM_STAGES'(1) << idx_d;
                stage_start_d = wd_clear ? stage_en_d : '0;
                busy_d        = 1'b1;
            end
            S_DONE:  finish_d = 1'b1;
            S_ERROR: terr_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            skip_q        <= '0;
            stage_en_q    <= '0;
            stage_start_q <= '0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
            terr_q        <= 1'b0;
            err_stage_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            skip_q        <= skip_d;
            stage_en_q    <= stage_en_d;
            stage_start_q <= stage_start_d;
            busy_q        <= busy_d;
            finish_q      <= finish_d;
            terr_q        <= terr_d;
            err_stage_q   <= err_stage_d;
        end
    end

    assign stage_en    = stage_en_q;
    assign stage_start = stage_start_q;
    assign cur_stage   = idx_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign timeout_err = terr_q;
    assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a cycle vector table plus hand-written
// sequences for stage walk, timeout, done-vs-timeout and asynchronous reset.
module tb_layer_sequencer;

    localparam int unsigned NS = 6;

    typedef struct packed {
        logic [5:0] en;
        logic [5:0] st;
        logic [2:0] cur;
        logic       busy;
        logic       fin;
        logic       terr;
        logic [2:0] err;
    } out_t;

    typedef struct {
        logic       start;
        logic       abort;
        logic [5:0] skip;
        logic [5:0] done;
        out_t       exp;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [NS-1:0] stage_skip;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_en;
    logic [NS-1:0] stage_start;
    logic [2:0]    cur_stage;
    logic          busy;
    logic          finish;
    logic          timeout_err;
    logic [2:0]    err_stage;
    out_t          act;

    int   n_vec;
    int   n_mis;
    out_t exp_q[$];
    vec_t tbl[20];

    layer_sequencer #(
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_W     (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .stage_skip (stage_skip),
        .stage_done (stage_done),
        .stage_en   (stage_en),
        .stage_start(stage_start),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .finish     (finish),
        .timeout_err(timeout_err),
        .err_stage  (err_stage)
    );

    assign act = {stage_en, stage_start, cur_stage, busy, finish, timeout_err, err_stage};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o_idle();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_run(input int s, input bit first);
        out_t o;
        o      = '0;
        o.en   = 6'b000001 << s;
        o.st   = first ? o.en : 6'b000000;
        o.cur  = 3'(s);
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t o_done();
        out_t o;
        o     = '0;
        o.fin = 1'b1;
        return o;
    endfunction

    function automatic out_t o_err(input int s);
        out_t o;
        o      = '0;
        o.terr = 1'b1;
        o.err  = 3'(s);
        return o;
    endfunction

    function automatic vec_t mkv(input logic st, input logic ab, input logic [5:0] sk,
                                 input logic [5:0] dn, input out_t e);
        vec_t v;
        v.start = st;
        v.abort = ab;
        v.skip  = sk;
        v.done  = dn;
        v.exp   = e;
        return v;
    endfunction

    task automatic check(input string name, input out_t e);
        n_vec++;
        if (act !== e) begin
            n_mis++;
            $display("FAIL %s: got en=%b st=%b cur=%0d busy=%b fin=%b terr=%b err=%0d, expected en=%b st=%b cur=%0d busy=%b fin=%b terr=%b err=%0d",
                     name, act.en, act.st, act.cur, act.busy, act.fin, act.terr, act.err,
                     e.en, e.st, e.cur, e.busy, e.fin, e.terr, e.err);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic step(input string name, input logic st, input logic ab,
                        input logic [5:0] sk, input logic [5:0] dn, input out_t e);
        start      = st;
        abort      = ab;
        stage_skip = sk;
        stage_done = dn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        n_vec      = 0;
        n_mis      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        stage_skip = '0;
        stage_done = '0;
        #2;
        check("reset_state", o_idle());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // skip 010110 run, skip latch, ignored stale done, all-skip, abort, held done, re-run
        tbl[0]  = mkv(1, 0, 6'b010110, 6'b000000, o_run(0, 1));
        tbl[1]  = mkv(0, 0, 6'b010110, 6'b000000, o_run(0, 0));
        tbl[2]  = mkv(0, 0, 6'b000000, 6'b000001, o_run(3, 1));
        tbl[3]  = mkv(0, 0, 6'b000000, 6'b000001, o_run(3, 0));
        tbl[4]  = mkv(0, 0, 6'b000000, 6'b001000, o_run(5, 1));
        tbl[5]  = mkv(0, 0, 6'b000000, 6'b001000, o_run(5, 0));
        tbl[6]  = mkv(0, 0, 6'b000000, 6'b100000, o_done());
        tbl[7]  = mkv(0, 0, 6'b000000, 6'b000000, o_done());
        tbl[8]  = mkv(0, 1, 6'b000000, 6'b000000, o_idle());
        tbl[9]  = mkv(1, 0, 6'b111111, 6'b000000, o_done());
        tbl[10] = mkv(1, 1, 6'b000000, 6'b000000, o_idle());
        tbl[11] = mkv(1, 0, 6'b000000, 6'b111111, o_run(0, 1));
        tbl[12] = mkv(0, 0, 6'b000000, 6'b111111, o_run(1, 1));
        tbl[13] = mkv(0, 0, 6'b000000, 6'b111111, o_run(2, 1));
        tbl[14] = mkv(0, 0, 6'b000000, 6'b111111, o_run(3, 1));
        tbl[15] = mkv(0, 0, 6'b000000, 6'b111111, o_run(4, 1));
        tbl[16] = mkv(0, 0, 6'b000000, 6'b111111, o_run(5, 1));
        tbl[17] = mkv(0, 0, 6'b000000, 6'b111111, o_done());
        tbl[18] = mkv(1, 0, 6'b111110, 6'b000000, o_run(0, 1));
        tbl[19] = mkv(0, 1, 6'b000000, 6'b000001, o_idle());
        for (int i = 0; i < 20; i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].start, tbl[i].abort,
                 tbl[i].skip, tbl[i].done, tbl[i].exp);
        end

        // Full walk, each done four cycles after its stage_start
        step("walk_start", 1, 0, 6'b0, 6'b0, o_run(0, 1));
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 4; k++) begin
                step($sformatf("walk_s%0d_k%0d", s, k), 0, 0, 6'b0, 6'b0, o_run(s, 0));
            end
            step($sformatf("walk_done%0d", s), 0, 0, 6'b0, 6'b000001 << s,
                 (s < 5) ? o_run(s + 1, 1) : o_done());
        end
        step("walk_abort", 0, 1, 6'b0, 6'b0, o_idle());

        // Stage 2 never completes; other stages' done bits are ignored
        step("to_start", 1, 0, 6'b0, 6'b000000, o_run(0, 1));
        step("to_s1",    0, 0, 6'b0, 6'b000001, o_run(1, 1));
        step("to_s2",    0, 0, 6'b0, 6'b000010, o_run(2, 1));
        for (int k = 0; k < 15; k++) begin
            step($sformatf("to_wait%0d", k), 0, 0, 6'b0, 6'b111011, o_run(2, 0));
        end
        step("to_expire",      0, 0, 6'b0, 6'b111011, o_err(2));
        step("to_start_ignored", 1, 0, 6'b0, 6'b000000, o_err(2));
        step("to_done_ignored",  0, 0, 6'b0, 6'b000100, o_err(2));
        step("to_abort",       0, 1, 6'b0, 6'b000000, o_idle());

        // Done arriving in the expiry cycle wins over the timeout
        step("dw_start", 1, 0, 6'b0, 6'b0, o_run(0, 1));
        for (int k = 0; k < 15; k++) begin
            step($sformatf("dw_wait%0d", k), 0, 0, 6'b0, 6'b0, o_run(0, 0));
        end
        step("dw_done_wins", 0, 0, 6'b0, 6'b000001, o_run(1, 1));
        step("dw_abort",     0, 1, 6'b0, 6'b000000, o_idle());

        // Asynchronous reset while stage 3 is active
        step("ar_start", 1, 0, 6'b0, 6'b000000, o_run(0, 1));
        step("ar_s1",    0, 0, 6'b0, 6'b000001, o_run(1, 1));
        step("ar_s2",    0, 0, 6'b0, 6'b000010, o_run(2, 1));
        step("ar_s3",    0, 0, 6'b0, 6'b000100, o_run(3, 1));
        step("ar_hold",  0, 0, 6'b0, 6'b000000, o_run(3, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_clk", o_idle());
        #1;
        rst_n = 1'b1;
        step("post_reset_idle",  0, 0, 6'b0, 6'b0, o_idle());
        step("post_reset_start", 1, 0, 6'b0, 6'b0, o_run(0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
